alu_op_scheduler: RTL and testbench
===================================

Name: alu_op_scheduler

Overview:
Front-end controller for the 16-bit signed ALU. Arbitrates round-robin between two requesters, decodes a 4-bit opcode into one unit enable plus a 2-bit sub-function, and drives the ALU operand bus. Waits for the registered unit result, then returns result and flag to the winning requester over a valid/ready response channel. Sits between the command sources and the ARITH/LOGIC/CMP/SHIFT units.

Parameters:
WIDTH, 16, operand and result width
ID_W, 1, requester id width (fixed to 1 for two requesters)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
Req_Valid  in  2  per-requester command valid, bit0 = requester 0
Req_Ready  out  2  per-requester accept; at most one bit high
Req0_A, Req0_B  in  WIDTH each  requester 0 operands
Req0_Op  in  4  requester 0 opcode
Req1_A, Req1_B  in  WIDTH each  requester 1 operands
Req1_Op  in  4  requester 1 opcode
ALU_A, ALU_B  out  WIDTH each  registered operands to all units
ALU_FUN  out  2  sub-function, Op[1:0]
Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  out  1 each  unit enables, one-hot or zero
Arith_Out, Logic_Out, CMP_Out, Shift_Out  in  WIDTH each  registered unit results
Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  registered unit flags
Resp_Valid  out  1  response valid
Resp_Ready  in  1  response consumer accept
Resp_Id  out  ID_W  requester that issued the command
Resp_Data  out  WIDTH  selected unit result
Resp_Flag  out  1  selected unit flag

Behaviour:
- Reset (async, rst low): state IDLE; all enables 0; ALU_A/ALU_B/ALU_FUN 0; Resp_Valid/Resp_Data/Resp_Flag/Resp_Id 0; rr pointer last_grant=1 (requester 0 wins first). Reset mid-operation abandons the command; no response is produced.
- Opcode decode, Op[3:2]: 00 ARITH, 01 LOGIC, 10 CMP, 11 SHIFT; Op[1:0] drives ALU_FUN.
- FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE: Req_Ready is combinational. If exactly one Req_Valid bit is set, that bit's Ready goes high. If both are set, Ready goes to the requester other than last_grant. On Valid&Ready, latch operands to ALU_A/ALU_B, Op into an internal register, and id; update last_grant; go to ISSUE. With no request, stay in IDLE.
- ISSUE (1 cycle): assert exactly the decoded unit enable; ALU_FUN=Op[1:0]; operands held stable. Go to CAPTURE.
- CAPTURE (1 cycle): enables all 0. Register the selected unit's Out/Flag into Resp_Data/Resp_Flag (the unit output now reflects the ISSUE cycle). Go to RESP.
- RESP: Resp_Valid=1; Resp_Data/Flag/Id held stable until Resp_Valid&Resp_Ready. On that handshake: Resp_Valid=0 next cycle, go to IDLE. Resp_Ready high in the same cycle Resp_Valid rises completes in one cycle.
- Req_Ready is 0 in every state except IDLE. There is one command in flight; no pipelining.
- Minimum latency: accept edge to Resp_Valid high = 3 cycles. Throughput is 1 command per 4 cycles with Resp_Ready tied high.
- Enables are never high outside ISSUE, and never more than one is high.
- Resp_Flag=0 means the unit did not flag valid. It is passed through unchanged and is not retried.
- ALU_A/ALU_B keep their last values after completion; there is no clearing.

Decomposition:
- Shared package alu_pkg: opcode class constants (OPC_ARITH=2'b00, OPC_LOGIC=2'b01, OPC_CMP=2'b10, OPC_SHIFT=2'b11), FSM state encodings (IDLE, ISSUE, CAPTURE, RESP), WIDTH default.
- One sub-module: rr_arbiter2. It holds the last_grant register and produces the Req_Ready vector from Req_Valid, with an advance strobe. The FSM, decode, and capture mux stay in the top.

Test Plan:
- Reset then Req0 only, A=16'h00F0, B=16'h0FF0, Op=4'b0100 (LOGIC AND) -> Req_Ready=2'b01 in IDLE; Logic_Enable high exactly 1 cycle with ALU_FUN=00; Resp_Valid 3 cycles after accept; Resp_Data=16'h00F0, Resp_Flag=1, Resp_Id=0.
- Both requesters held valid continuously, each with a distinct Op -> grants alternate 0,1,0,1 over 4 commands; Resp_Id sequence 0,1,0,1; no requester is starved.
- Resp_Ready low for 5 cycles during RESP -> Resp_Valid stays high; Data/Flag/Id stable; Req_Ready stays 2'b00; a new request waiting is not accepted until after the handshake.
- Op sweep 4'b0000..4'b1111 -> exactly one correct enable pulses per command; ALU_FUN equals Op[1:0]; a mocked unit returning flag 0 gives Resp_Flag=0.
- rst asserted during ISSUE and during RESP -> all outputs 0 immediately (async); after release, Req0 is granted first and no stale response appears.
- Resp_Ready tied high, 10 back-to-back commands -> one response every 4 cycles, data matching a reference model.

Source files
------------

// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and constants for the ALU operation scheduler.
// Opcode classes, FSM states and the unit-enable decode helper.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] OPC_ARITH = 2'b00;
    localparam logic [1:0] OPC_LOGIC = 2'b01;
    localparam logic [1:0] OPC_CMP   = 2'b10;
    localparam logic [1:0] OPC_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_t;

    // Bit order {shift, cmp, logic, arith}
    function automatic logic [3:0] unit_onehot(input logic [1:0] cls);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (cls)
            OPC_ARITH: oh = 4'b0001;
            OPC_LOGIC: oh = 4'b0010;
            OPC_CMP:   oh = 4'b0100;
            OPC_SHIFT: oh = 4'b1000;
            default:   oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter for the ALU scheduler front end.
// Holds the last grant; the advance strobe records the current winner.
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] req_ready,
    output logic       grant_id
);

    logic last_grant;

    always_comb begin
        req_ready = 2'b00;
        if (enable) begin
            unique case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign grant_id = req_ready[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Front-end controller for the 16-bit ALU: arbitrates two requesters,
// issues one command at a time and returns the unit result.
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       Req_Valid,
    output logic [1:0]       Req_Ready,
    input  logic [WIDTH-1:0] Req0_A,
    input  logic [WIDTH-1:0] Req0_B,
    input  logic [3:0]       Req0_Op,
    input  logic [WIDTH-1:0] Req1_A,
    input  logic [WIDTH-1:0] Req1_B,
    input  logic [3:0]       Req1_Op,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [1:0]       ALU_FUN,
    output logic             Arith_Enable,
    output logic             Logic_Enable,
    output logic             CMP_Enable,
    output logic             Shift_Enable,
    input  logic [WIDTH-1:0] Arith_Out,
    input  logic [WIDTH-1:0] Logic_Out,
    input  logic [WIDTH-1:0] CMP_Out,
    input  logic [WIDTH-1:0] Shift_Out,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag,
    output logic             Resp_Valid,
    input  logic             Resp_Ready,
    output logic [ID_W-1:0]  Resp_Id,
    output logic [WIDTH-1:0] Resp_Data,
    output logic             Resp_Flag
);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      op_q;
    logic [ID_W-1:0] id_q;
    logic            arb_en;
    logic            grant_id;
    logic            accept;
    logic [3:0]      en_vec;
    logic [WIDTH-1:0] sel_data;
    logic            sel_flag;

    // Ready is also gated by reset so all outputs drop while rst is low
    assign arb_en = (state == IDLE) && rst;
    assign accept = arb_en && ((Req_Valid & Req_Ready) != 2'b00);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (Req_Valid),
        .enable    (arb_en),
        .advance   (accept),
        .req_ready (Req_Ready),
        .grant_id  (grant_id)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (Resp_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign en_vec = (state == ISSUE) ? unit_onehot(op_q[3:2]) : 4'b0000;
    assign Arith_Enable = en_vec[0];
    assign Logic_Enable = en_vec[1];
    assign CMP_Enable   = en_vec[2];
    assign Shift_Enable = en_vec[3];

    assign Resp_Valid = (state == RESP);

    always_comb begin
        sel_data = '0;
        sel_flag = 1'b0;
        unique case (op_q[3:2])
            OPC_ARITH: begin
                sel_data = Arith_Out;
                sel_flag = Arith_Flag;
            end
            OPC_LOGIC: begin
                sel_data = Logic_Out;
                sel_flag = Logic_Flag;
            end
            OPC_CMP: begin
                sel_data = CMP_Out;
                sel_flag = CMP_Flag;
            end
            OPC_SHIFT: begin
                sel_data = Shift_Out;
                sel_flag = Shift_Flag;
            end
            default: begin
                sel_data = '0;
                sel_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALU_A   <= '0;
            ALU_B   <= '0;
            ALU_FUN <= 2'b00;
            op_q    <= 4'h0;
            id_q    <= '0;
        end else if (accept) begin
            ALU_A   <= grant_id ? Req1_A : Req0_A;
            ALU_B   <= grant_id ? Req1_B : Req0_B;
            ALU_FUN <= grant_id ? Req1_Op[1:0] : Req0_Op[1:0];
            op_q    <= grant_id ? Req1_Op : Req0_Op;
            id_q    <= ID_W'(grant_id);
        end
    end

    // Unit outputs registered on the ISSUE edge are valid during CAPTURE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Resp_Data <= '0;
            Resp_Flag <= 1'b0;
            Resp_Id   <= '0;
        end else if (state == CAPTURE) begin
            Resp_Data <= sel_data;
            Resp_Flag <= sel_flag;
            Resp_Id   <= id_q;
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed self-checking bench for alu_op_scheduler with mocked
// registered ALU units.
module tb_alu_op_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  Req_Valid = 2'b00;
    logic [1:0]  Req_Ready;
    logic [15:0] Req0_A = '0, Req0_B = '0, Req1_A = '0, Req1_B = '0;
    logic [3:0]  Req0_Op = '0, Req1_Op = '0;
    logic [15:0] ALU_A, ALU_B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] Arith_Out, Logic_Out, CMP_Out, Shift_Out;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
    logic        Resp_Valid;
    logic        Resp_Ready = 1'b0;
    logic [0:0]  Resp_Id;
    logic [15:0] Resp_Data;
    logic        Resp_Flag;
    logic [3:0]  en;

    int n_checks = 0;
    int n_fail = 0;

    logic        g_to, g_multi, g_stall_bad, g_busy_rdy, g_after_valid;
    logic        g_id, g_flag, g_rid;
    logic [1:0]  g_ready, g_fun;
    logic [3:0]  g_en_vec;
    int          g_en_cnt, g_lat;
    logic [15:0] g_data;
    logic [16:0] g_exp;
    time         g_t_acc;

    always #5 clk = ~clk;

    assign en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

    alu_op_scheduler dut (
        .clk(clk), .rst(rst),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Op(Req0_Op),
        .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Op(Req1_Op),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_Out(Arith_Out), .Logic_Out(Logic_Out),
        .CMP_Out(CMP_Out), .Shift_Out(Shift_Out),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
        .Resp_Id(Resp_Id), .Resp_Data(Resp_Data), .Resp_Flag(Resp_Flag)
    );

    // Unit behaviour model: {flag, result}; flag is set for a nonzero result
    function automatic logic [16:0] umodel(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        r = '0;
        case (op[3:2])
            2'b00: case (op[1:0])
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = {a[7:0], b[7:0]};
                default: r = b - a;
            endcase
            2'b01: case (op[1:0])
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = ~(a & b);
            endcase
            2'b10: case (op[1:0])
                2'd0: r = {15'b0, a == b};
                2'd1: r = {15'b0, $signed(a) < $signed(b)};
                2'd2: r = {15'b0, $signed(a) > $signed(b)};
                default: r = {15'b0, a != b};
            endcase
            default: case (op[1:0])
                2'd0: r = a << b[3:0];
                2'd1: r = a >> b[3:0];
                2'd2: r = 16'($signed(a) >>> b[3:0]);
                default: r = {a[14:0], a[15]};
            endcase
        endcase
        return {|r, r};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            {Arith_Flag, Arith_Out} <= '0;
            {Logic_Flag, Logic_Out} <= '0;
            {CMP_Flag, CMP_Out}     <= '0;
            {Shift_Flag, Shift_Out} <= '0;
        end else begin
            if (Arith_Enable)
                {Arith_Flag, Arith_Out} <= umodel({2'b00, ALU_FUN}, ALU_A, ALU_B);
            if (Logic_Enable)
                {Logic_Flag, Logic_Out} <= umodel({2'b01, ALU_FUN}, ALU_A, ALU_B);
            if (CMP_Enable)
                {CMP_Flag, CMP_Out} <= umodel({2'b10, ALU_FUN}, ALU_A, ALU_B);
            if (Shift_Enable)
                {Shift_Flag, Shift_Out} <= umodel({2'b11, ALU_FUN}, ALU_A, ALU_B);
        end
    end

    // Drives one command through to its response handshake and records
    // what was observed; callers do the comparisons.
    task automatic run_one(input bit drop, input int stall, input bit inject);
        int n;
        g_to = 0; g_en_cnt = 0; g_en_vec = '0; g_multi = 0; g_fun = '0;
        g_stall_bad = 0; g_busy_rdy = 0; g_after_valid = 0;
        n = 0;
        while (((Req_Valid & Req_Ready) == 2'b00) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) begin g_to = 1; return; end
        g_ready = Req_Ready;
        g_id = Req_Ready[1];
        g_exp = g_id ? umodel(Req1_Op, Req1_A, Req1_B)
                     : umodel(Req0_Op, Req0_A, Req0_B);
        g_t_acc = $time;
        @(posedge clk); #1;
        if (drop) Req_Valid[g_id] = 1'b0;
        g_lat = 1;
        while (!Resp_Valid && g_lat < 10) begin
            if (en != 4'b0000) begin
                g_en_cnt++;
                g_en_vec = g_en_vec | en;
                g_fun = ALU_FUN;
                if ($countones(en) > 1) g_multi = 1;
            end
            if (Req_Ready != 2'b00) g_busy_rdy = 1;
            @(posedge clk); #1; g_lat++;
        end
        if (!Resp_Valid) begin g_to = 1; return; end
        g_data = Resp_Data; g_flag = Resp_Flag; g_rid = Resp_Id[0];
        if (inject) Req_Valid[1] = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            if (Resp_Valid !== 1'b1 || Resp_Data !== g_data ||
                Resp_Flag !== g_flag || Resp_Id[0] !== g_rid ||
                Req_Ready !== 2'b00 || en !== 4'b0000)
                g_stall_bad = 1;
        end
        Resp_Ready = 1'b1;
        @(posedge clk); #1;
        g_after_valid = Resp_Valid;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        Req_Valid = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({en, Resp_Valid, Req_Ready, ALU_A, ALU_B, ALU_FUN} !== '0 ||
            {Resp_Data, Resp_Flag, Resp_Id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b rv=%b rdy=%b a=%h d=%h",
                     en, Resp_Valid, Req_Ready, ALU_A, Resp_Data);
        end
        Req_Valid = 2'b00;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_logic();
        Req0_A = 16'h00F0; Req0_B = 16'h0FF0; Req0_Op = 4'b0100;
        Req_Valid = 2'b01; Resp_Ready = 1'b1;
        #1;
        n_checks++;
        if (Req_Ready !== 2'b01) begin
            n_fail++; $display("FAIL single_ready: got %b exp 01", Req_Ready);
        end
        run_one(1, 0, 0);
        n_checks++;
        if (g_to || g_en_vec !== 4'b0010 || g_en_cnt != 1 || g_fun !== 2'b00) begin
            n_fail++;
            $display("FAIL single_enable: to=%0d en=%b cnt=%0d fun=%b exp 0010/1/00",
                     g_to, g_en_vec, g_en_cnt, g_fun);
        end
        n_checks++;
        if (g_lat != 3) begin
            n_fail++; $display("FAIL single_latency: got %0d exp 3", g_lat);
        end
        n_checks++;
        if (g_data !== 16'h00F0 || g_flag !== 1'b1 || g_rid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: got %h/%b/%b exp 00f0/1/0",
                     g_data, g_flag, g_rid);
        end
        n_checks++;
        if (g_after_valid !== 1'b0 || ALU_A !== 16'h00F0 || ALU_B !== 16'h0FF0) begin
            n_fail++;
            $display("FAIL single_after: rv=%b a=%h b=%h exp 0/00f0/0ff0",
                     g_after_valid, ALU_A, ALU_B);
        end
    endtask

    task automatic test_alternate();
        pulse_reset();
        Req0_A = 16'h0005; Req0_B = 16'h0003; Req0_Op = 4'b0000;
        Req1_A = 16'h0005; Req1_B = 16'h0003; Req1_Op = 4'b0001;
        Req_Valid = 2'b11; Resp_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_one(0, 0, 0);
            n_checks++;
            if (g_to || g_id !== 1'(i % 2) || g_rid !== 1'(i % 2) ||
                g_data !== ((i % 2) ? 16'h0002 : 16'h0008)) begin
                n_fail++;
                $display("FAIL alternate_%0d: grant=%b id=%b data=%h exp id %0d",
                         i, g_id, g_rid, g_data, i % 2);
            end
        end
        Req_Valid = 2'b00;
    endtask

    task automatic test_stall();
        Req0_A = 16'h00F0; Req0_B = 16'h0F00; Req0_Op = 4'b0101;
        Req1_A = 16'h8001; Req1_B = 16'h0000; Req1_Op = 4'b1111;
        Req_Valid = 2'b01; Resp_Ready = 1'b0;
        run_one(1, 5, 1);
        n_checks++;
        if (g_to || g_stall_bad || g_data !== 16'h0FF0 || g_after_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: to=%0d bad=%0d data=%h rv=%b exp 0/0/0ff0/0",
                     g_to, g_stall_bad, g_data, g_after_valid);
        end
        n_checks++;
        if (Req_Ready !== 2'b10) begin
            n_fail++; $display("FAIL stall_pending: got %b exp 10", Req_Ready);
        end
        run_one(1, 0, 0);
        n_checks++;
        if (g_to || g_rid !== 1'b1 || g_data !== 16'h0003 || g_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_next: id=%b data=%h flag=%b exp 1/0003/1",
                     g_rid, g_data, g_flag);
        end
    endtask

    task automatic test_op_sweep();
        Req0_A = 16'h8421; Req0_B = 16'h0003;
        Resp_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Req0_Op = 4'(i);
            Req_Valid = 2'b01;
            run_one(1, 0, 0);
            n_checks++;
            if (g_to || g_multi || g_en_cnt != 1 ||
                g_en_vec !== (4'b0001 << Req0_Op[3:2]) || g_fun !== Req0_Op[1:0]) begin
                n_fail++;
                $display("FAIL sweep_en_%0d: en=%b cnt=%0d fun=%b multi=%0d",
                         i, g_en_vec, g_en_cnt, g_fun, g_multi);
            end
            n_checks++;
            if ({g_flag, g_data} !== g_exp) begin
                n_fail++;
                $display("FAIL sweep_data_%0d: got %b/%h exp %b/%h",
                         i, g_flag, g_data, g_exp[16], g_exp[15:0]);
            end
            if (i == 8) begin
                n_checks++;
                if (g_flag !== 1'b0 || g_data !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL sweep_flag0: got %b/%h exp 0/0000", g_flag, g_data);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        pulse_reset();
        Req0_A = 16'h1111; Req0_B = 16'h2222; Req0_Op = 4'b0000;
        Req_Valid = 2'b01;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_checks++;
        if ({en, Resp_Valid, Req_Ready, ALU_A, ALU_B, ALU_FUN} !== '0) begin
            n_fail++;
            $display("FAIL rst_issue: en=%b rdy=%b a=%h exp 0", en, Req_Ready, ALU_A);
        end
        Req_Valid = 2'b00;
        @(negedge clk); rst = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (Resp_Valid) seen = 1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rst_issue_stale: got 1 exp 0"); end
        Req0_A = 16'h00FF; Req0_B = 16'h0F0F; Req0_Op = 4'b0101;
        Req_Valid = 2'b01; Resp_Ready = 1'b0;
        @(posedge clk); #1;
        Req_Valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (Resp_Valid !== 1'b1 || Resp_Data !== 16'h0FFF) begin
            n_fail++;
            $display("FAIL rst_resp_pre: rv=%b data=%h exp 1/0fff", Resp_Valid, Resp_Data);
        end
        rst = 1'b0; #1;
        n_checks++;
        if ({Resp_Valid, Resp_Data, Resp_Flag, Resp_Id, ALU_A} !== '0) begin
            n_fail++;
            $display("FAIL rst_resp: rv=%b data=%h flag=%b id=%b exp 0",
                     Resp_Valid, Resp_Data, Resp_Flag, Resp_Id);
        end
        @(negedge clk); rst = 1'b1; Resp_Ready = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (Resp_Valid) seen = 1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rst_resp_stale: got 1 exp 0"); end
        Req_Valid = 2'b11; #1;
        n_checks++;
        if (Req_Ready !== 2'b01) begin
            n_fail++; $display("FAIL rst_first_grant: got %b exp 01", Req_Ready);
        end
        Req_Valid = 2'b00;
    endtask

    task automatic test_back_to_back();
        time prev;
        pulse_reset();
        Resp_Ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            Req0_A = 16'(i * 16'h0111 + 1);
            Req0_B = 16'(i + 1);
            Req0_Op = 4'(i * 5);
            Req_Valid = 2'b01;
            run_one(0, 0, 0);
            n_checks++;
            if (g_to || {g_flag, g_data} !== g_exp) begin
                n_fail++;
                $display("FAIL b2b_data_%0d: got %b/%h exp %b/%h",
                         i, g_flag, g_data, g_exp[16], g_exp[15:0]);
            end
            if (i > 0) begin
                n_checks++;
                if (g_t_acc - prev != 40) begin
                    n_fail++;
                    $display("FAIL b2b_rate_%0d: got %0t exp 40", i, g_t_acc - prev);
                end
            end
            prev = g_t_acc;
        end
        Req_Valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_logic();
        test_alternate();
        test_stall();
        test_op_sweep();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
